// File: rtl/jtkicker_obj_linebuf_pkg.sv
// ============================================================================
// Module      : jtkicker_obj_linebuf_pkg
// Description : Shared types for the object line buffer. Holds the state
//               encoding of the clear-sweep / run controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtkicker_obj_linebuf_pkg;

    // Controller states: INIT sweeps zeros through both banks, RUN is normal
    // double-buffered operation.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lb_state_e;

endpackage

`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
// ============================================================================
// Module      : jtframe_dual_ram
// Description : Simple dual-port RAM, one bank of the object line buffer.
//               Port A : write only (draw engine / clear sweep).
//               Port B : asynchronous read plus write (scan-out / erase).
// Ports       : clk            - system clock
//               we_a/addr_a/data_a - port A write strobe, address, data
//               we_b/addr_b/data_b - port B write strobe, address, data
//               q_b            - port B read data at addr_b (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_dual_ram #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem_q [2**AW];

    // If both ports ever hit the same word in one clk, port A (draw) wins,
    // so a freshly drawn pixel is never lost to a stale erase.
    always_ff @(posedge clk) begin
        if (we_b) mem_q[addr_b] <= data_b;
        if (we_a) mem_q[addr_a] <= data_a;
    end

    assign q_b = mem_q[addr_b];

endmodule

`default_nettype wire

// File: rtl/jtkicker_obj_linebuf.sv
// ============================================================================
// Module      : jtkicker_obj_linebuf
// Description : Double-buffered object line buffer. The draw engine renders
//               the next line into one bank while the other bank is scanned
//               out; every read location is erased one clk after it is read.
//               Banks swap on each qualified hinit.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               pxl_cen        - pixel clock enable
//               hinit          - line start strobe (qualified by pxl_cen)
//               LHBL           - horizontal blank, active low
//               hdump          - horizontal position, [AW-1:0] used
//               flip           - horizontal mirror of read address
//               draw_we/addr/pxl - draw-side write port
//               init_done      - high once the post-reset clear has finished
//               pxl            - object pixel to the colour mixer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkicker_obj_linebuf
    import jtkicker_obj_linebuf_pkg::*;
#(
    parameter int          AW      = 8,
    parameter int          DW      = 4,
    parameter int unsigned HOFFSET = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          hinit,
    input  logic          LHBL,
    input  logic [8:0]    hdump,
    input  logic          flip,
    input  logic          draw_we,
    input  logic [AW-1:0] draw_addr,
    input  logic [DW-1:0] draw_pxl,
    output logic          init_done,
    output logic [DW-1:0] pxl
);

    localparam logic [AW-1:0] HOFF = HOFFSET[AW-1:0];

    lb_state_e     state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          bank_q, bank_d;
    logic [DW-1:0] pxl_q, pxl_d;
    logic          erase_pend_q, erase_pend_d;
    logic [AW-1:0] erase_addr_q, erase_addr_d;
    logic          erase_bank_q, erase_bank_d;

    logic          run;
    logic          rd_strobe;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] bank_rd [2];
    logic          unused_hdump;

    assign unused_hdump = ^hdump[8:AW];

    assign run       = (state_q == ST_RUN);
    assign rd_addr   = (flip ? ~hdump[AW-1:0] : hdump[AW-1:0]) + HOFF;
    assign rd_strobe = run & pxl_cen & LHBL;
    assign rd_data   = bank_q ? bank_rd[1] : bank_rd[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= '0;
            bank_q       <= 1'b0;
            pxl_q        <= '0;
            erase_pend_q <= 1'b0;
            erase_addr_q <= '0;
            erase_bank_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            bank_q       <= bank_d;
            pxl_q        <= pxl_d;
            erase_pend_q <= erase_pend_d;
            erase_addr_q <= erase_addr_d;
            erase_bank_q <= erase_bank_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        bank_d       = bank_q ^ (pxl_cen & hinit);
        pxl_d        = pxl_q;
        // The erase remembers the bank it read from, so a swap landing on
        // the read pxl_cen still clears the bank that was actually scanned.
        erase_pend_d = rd_strobe;
        erase_addr_d = rd_strobe ? rd_addr : erase_addr_q;
        erase_bank_d = rd_strobe ? bank_q  : erase_bank_q;

        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {AW{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase

        if (!run) begin
            pxl_d = '0;
        end else if (pxl_cen) begin
            pxl_d = LHBL ? rd_data : '0;
        end
    end

    // ------------------------------------------------------------------
    // Banks. Port A: clear sweep (both banks) or draw (draw bank only).
    // Port B: scan-out read, and the erase one clk later. pxl_cen is never
    // active on two consecutive clks, so read and erase do not collide.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_bank
        localparam logic BANK_ID = 1'(i);

        logic          we_a, we_b;
        logic [AW-1:0] addr_a, addr_b;
        logic [DW-1:0] data_a;

        assign we_a   = run ? (draw_we && (draw_pxl != '0) && (bank_q != BANK_ID))
                            : 1'b1;
        assign addr_a = run ? draw_addr : clr_cnt_q;
        assign data_a = run ? draw_pxl  : '0;
        assign we_b   = erase_pend_q && (erase_bank_q == BANK_ID);
        assign addr_b = we_b ? erase_addr_q : rd_addr;

        jtframe_dual_ram #(
            .AW (AW),
            .DW (DW)
        ) u_ram (
            .clk    (clk),
            .we_a   (we_a),
            .addr_a (addr_a),
            .data_a (data_a),
            .we_b   (we_b),
            .addr_b (addr_b),
            .data_b ({DW{1'b0}}),
            .q_b    (bank_rd[i])
        );
    end

    assign init_done = run;
    assign pxl       = pxl_q;

endmodule

`default_nettype wire

// File: tb/tb_jtkicker_obj_linebuf.sv
// ============================================================================
// Module      : tb_jtkicker_obj_linebuf
// Description : Self-checking bench for the object line buffer. Two DUTs
//               (HOFFSET 0 and 2) share the stimulus; a line-level model
//               predicts every scanned pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtkicker_obj_linebuf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pxl_cen = 1'b0;
    logic       hinit = 1'b0;
    logic       LHBL = 1'b0;
    logic [8:0] hdump = '0;
    logic       flip = 1'b0;
    logic       draw_we = 1'b0;
    logic [7:0] draw_addr = '0;
    logic [3:0] draw_pxl = '0;
    logic       init_done0, init_done2;
    logic [3:0] pxl0, pxl2;

    always #5 clk = ~clk;

    jtkicker_obj_linebuf #(.AW(8), .DW(4), .HOFFSET(0)) u_dut0 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .hdump(hdump), .flip(flip), .draw_we(draw_we), .draw_addr(draw_addr),
        .draw_pxl(draw_pxl), .init_done(init_done0), .pxl(pxl0)
    );

    jtkicker_obj_linebuf #(.AW(8), .DW(4), .HOFFSET(2)) u_dut2 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hinit(hinit), .LHBL(LHBL),
        .hdump(hdump), .flip(flip), .draw_we(draw_we), .draw_addr(draw_addr),
        .draw_pxl(draw_pxl), .init_done(init_done2), .pxl(pxl2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- line-level reference model ----------------
    // dm: picture being drawn for the next line; rm: picture shown this line.
    typedef struct { int a; int v; } draw_t;
    draw_t dq[$];
    int    dm [256];
    int    rm [256];
    int    cap0 [256];
    int    cap2 [256];
    int    hcount = 0;
    bit    co_en = 0;
    int    co_addr = 0;
    int    co_val = 0;

    function automatic int rdaddr(input int h, input bit fl, input int off);
        int a;
        a = fl ? (255 - (h % 256)) : (h % 256);
        return (a + off) % 256;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            dm[i] = 0;
            rm[i] = 0;
        end
        dq.delete();
        hcount = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held, then released; measures clk count to init_done.
    task automatic init_seq();
        int first0 = 0;
        int first2 = 0;
        pxl_cen = 0; hinit = 0; draw_we = 0; LHBL = 0;
        repeat (3) step();
        chk("rst_pxl0", {28'd0, pxl0}, 0);
        chk("rst_pxl2", {28'd0, pxl2}, 0);
        chk("rst_done0", {31'd0, init_done0}, 0);
        rst = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            pxl_cen   = (cyc % 8 == 0);
            LHBL      = 1'b1;
            hdump     = 9'($urandom_range(0, 511));
            draw_we   = (first0 == 0);
            draw_addr = 8'($urandom);
            draw_pxl  = 4'($urandom_range(1, 15));
            step();
            if (init_done0 && first0 == 0) first0 = cyc;
            if (init_done2 && first2 == 0) first2 = cyc;
            if (pxl_cen && cyc <= 256 && (cyc % 64 == 0))
                chk("init_pxl", {28'd0, pxl0}, 0);
            if (first0 != 0 && first2 != 0) break;
        end
        chk("init_lat0", first0, 256);
        chk("init_lat2", first2, 256);
        draw_we = 0; pxl_cen = 0; LHBL = 0;
        clear_model();
    endtask

    // One full line: 16 blank pixels then 256 active. Queued draws are issued
    // on non-pxl_cen clks. abort_p >= 0 asserts rst mid-line at that pixel.
    task automatic run_line(input bit fl, input int abort_p);
        draw_t d;
        int    h, e0, e2;
        flip = fl;
        for (int p = 0; p < 272; p++) begin
            for (int s = 0; s < 8; s++) begin
                pxl_cen = (s == 0);
                hinit   = (p == 0 && s == 0);
                LHBL    = (p >= 16);
                h       = p - 16;
                hdump   = (p >= 16) ? 9'(h) : 9'(256 + p);
                draw_we = 0;
                if (p == 0 && s == 0 && co_en) begin
                    draw_we = 1; draw_addr = 8'(co_addr); draw_pxl = 4'(co_val);
                end else if (s != 0 && dq.size() > 0) begin
                    d = dq.pop_front();
                    draw_we = 1; draw_addr = 8'(d.a); draw_pxl = 4'(d.v);
                end
                if (p == abort_p && s == 2) begin
                    #3 rst = 1'b1;
                    #1;
                    chk("abort_pxl0", {28'd0, pxl0}, 0);
                    chk("abort_done0", {31'd0, init_done0}, 0);
                    chk("abort_pxl2", {28'd0, pxl2}, 0);
                    draw_we = 0; pxl_cen = 0; hinit = 0;
                    return;
                end
                step();
                if (draw_we && draw_pxl != 0) dm[draw_addr] = int'(draw_pxl);
                if (hinit) begin
                    for (int i = 0; i < 256; i++) begin
                        rm[i] = dm[i];
                        dm[i] = 0;
                    end
                    hcount++;
                end
                if (s == 0) begin
                    e0 = (p >= 16) ? rm[rdaddr(h, fl, 0)] : 0;
                    e2 = (p >= 16) ? rm[rdaddr(h, fl, 2)] : 0;
                    if (p >= 16) begin
                        cap0[h] = int'(pxl0);
                        cap2[h] = int'(pxl2);
                    end
                    if (pxl0 !== 4'(e0) || p % 16 == 5)
                        chk($sformatf("pxl0 p=%0d", p), {28'd0, pxl0}, e0);
                    if (pxl2 !== 4'(e2) || p % 16 == 9)
                        chk($sformatf("pxl2 p=%0d", p), {28'd0, pxl2}, e2);
                end
            end
        end
        draw_we = 0; hinit = 0; pxl_cen = 0;
    endtask

    task automatic push_draw(input int a, input int v);
        draw_t d;
        d.a = a; d.v = v;
        dq.push_back(d);
    endtask

    initial begin
        // 1: reset, clear sweep, blank line
        init_seq();
        run_line(0, -1);
        run_line(0, -1);

        // 2: single pixel, then erase; HOFFSET=2 shifts it to 0x0E
        push_draw(8'h10, 5);
        run_line(0, -1);
        run_line(0, -1);
        chk("t2_hit0", cap0[8'h10], 5);
        chk("t2_hoff2", cap2[8'h0E], 5);
        run_line(0, -1);
        chk("t2_erase", cap0[8'h10], 0);

        // 3: flipped read
        push_draw(8'h10, 5);
        run_line(1, -1);
        run_line(1, -1);
        chk("t3_flip0", cap0[8'hEF], 5);
        chk("t3_flip2", cap2[8'hF1], 5);

        // 4: overwrite and transparent writes
        push_draw(8'h80, 3); push_draw(8'h80, 0); push_draw(8'h80, 7);
        push_draw(8'h40, 3); push_draw(8'h40, 0);
        run_line(0, -1);
        run_line(0, -1);
        chk("t4_over", cap0[8'h80], 7);
        chk("t4_transp", cap0[8'h40], 3);

        // 5: draw coincident with the swap belongs to the pre-swap draw bank
        co_en = 1; co_addr = 8'h33; co_val = 4'hA;
        run_line(0, -1);
        co_en = 0;
        chk("t5_coinc", cap0[8'h33], 10);
        run_line(0, -1);
        chk("t5_next", cap0[8'h33], 0);

        // random lines
        for (int l = 0; l < 6; l++) begin
            int n;
            n = $urandom_range(0, 40);
            for (int k = 0; k < n; k++)
                push_draw($urandom_range(0, 255), $urandom_range(0, 15));
            run_line(1'($urandom_range(0, 1)), -1);
        end

        // 6: reset mid-line while bank=1 and pxl non-zero
        do begin
            push_draw(8'h20, 9);
            run_line(0, -1);
        end while (hcount % 2 != 0);
        for (int k = 0; k < 30; k++)
            push_draw($urandom_range(0, 255), $urandom_range(1, 15));
        run_line(0, 16 + 8'h20);
        init_seq();
        run_line(0, -1);
        run_line(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
